// File: rtl/sine_lut_pkg.sv
// Shared constants and state encoding for the quarter-wave sine table.
// Defaults must stay in step with the phase-to-amplitude lookup logic.
package sine_lut_pkg;

    localparam int LUT_ADDR_WIDTH = 11;
    localparam int LUT_DATA_WIDTH = 12;
    localparam int CHECKSUM_WIDTH = 16;

    typedef enum logic {
        LOAD = 1'b0,
        RUN  = 1'b1
    } lut_state_e;

endpackage

// File: rtl/sine_lut_quarterwave_rom_if.sv
// Read ports and host load stream of the quarter-wave table responder.
// slave is the table side, master is the consumer/host side.
interface sine_lut_quarterwave_rom_if
    import sine_lut_pkg::*;
#(
    parameter int ADDR_WIDTH = LUT_ADDR_WIDTH,
    parameter int DATA_WIDTH = LUT_DATA_WIDTH
) ();

    logic                  i_en;
    logic [ADDR_WIDTH-1:0] i_addr_sin;
    logic [ADDR_WIDTH-1:0] i_addr_cos;
    logic [DATA_WIDTH-1:0] o_data_sin;
    logic [DATA_WIDTH-1:0] o_data_cos;
    logic [DATA_WIDTH-1:0] i_load_data;
    logic                  i_load_valid;
    logic                  o_load_ready;
    logic                  i_reload;
    logic                  o_ready;
    logic                  o_err;

    modport slave (
        input  i_en, i_addr_sin, i_addr_cos, i_load_data, i_load_valid, i_reload,
        output o_data_sin, o_data_cos, o_load_ready, o_ready, o_err
    );

    modport master (
        output i_en, i_addr_sin, i_addr_cos, i_load_data, i_load_valid, i_reload,
        input  o_data_sin, o_data_cos, o_load_ready, o_ready, o_err
    );

endinterface

// File: rtl/sine_lut_bank.sv
// Simple 1W1R synchronous RAM with registered read data (iCE40 EBR style).
// Contents and read register are deliberately not reset.
module sine_lut_bank
    import sine_lut_pkg::*;
#(
    parameter int ADDR_WIDTH = LUT_ADDR_WIDTH,
    parameter int DATA_WIDTH = LUT_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data_p1
);

    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data_p1 <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/sine_lut_quarterwave_rom.sv
// Run-time loadable quarter-wave sine/cos table with 1-cycle read latency.
// Optional load checksum enabled by SINE_LUT_QUARTERWAVE_ROM_CHECKSUM_EN.
module sine_lut_quarterwave_rom
    import sine_lut_pkg::*;
#(
    parameter int                        ADDR_WIDTH = LUT_ADDR_WIDTH,
    parameter int                        DATA_WIDTH = LUT_DATA_WIDTH,
    parameter logic [CHECKSUM_WIDTH-1:0] CHECKSUM   = '0
) (
    input  logic                        i_clk,
    input  logic                        i_rst_n,
    sine_lut_quarterwave_rom_if.slave   bus
);

    lut_state_e            state;
    logic [ADDR_WIDTH-1:0] cnt;
    logic                  ready;
    logic                  load_ready;
    logic                  vld_p1;
    logic                  accept;
    logic                  wr_en;
    logic                  last_word;
    logic                  rd_en;
    logic [DATA_WIDTH-1:0] q_sin_p1;
    logic [DATA_WIDTH-1:0] q_cos_p1;

    assign accept    = (state == LOAD) && load_ready && bus.i_load_valid;
    assign wr_en     = accept && !bus.i_reload;
    assign last_word = (cnt == '1);
    assign rd_en     = (state == RUN) && bus.i_en;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state      <= LOAD;
            cnt        <= '0;
            ready      <= 1'b0;
            load_ready <= 1'b0;
            vld_p1     <= 1'b0;
        end else begin
            case (state)
                LOAD: begin
                    vld_p1     <= 1'b0;
                    load_ready <= 1'b1;
                    if (bus.i_reload) begin
                        cnt <= '0;
                    end else if (wr_en) begin
                        cnt <= cnt + 1'b1;
                        if (last_word) begin
                            state      <= RUN;
                            ready      <= 1'b1;
                            load_ready <= 1'b0;
                        end
                    end
                end
                RUN: begin
                    if (bus.i_reload) begin
                        state      <= LOAD;
                        cnt        <= '0;
                        ready      <= 1'b0;
                        load_ready <= 1'b1;
                        vld_p1     <= 1'b0;
                    end else if (bus.i_en) begin
                        vld_p1 <= 1'b1;
                    end
                end
                default: state <= LOAD;
            endcase
        end
    end

    // Stage p1: bank read registers; vld_p1 masks them to zero until a RUN read lands
    sine_lut_bank #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_bank_sin (
        .clk        (i_clk),
        .wr_en      (wr_en),
        .wr_addr    (cnt),
        .wr_data    (bus.i_load_data),
        .rd_en      (rd_en),
        .rd_addr    (bus.i_addr_sin),
        .rd_data_p1 (q_sin_p1)
    );

    sine_lut_bank #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_bank_cos (
        .clk        (i_clk),
        .wr_en      (wr_en),
        .wr_addr    (cnt),
        .wr_data    (bus.i_load_data),
        .rd_en      (rd_en),
        .rd_addr    (bus.i_addr_cos),
        .rd_data_p1 (q_cos_p1)
    );

    assign bus.o_data_sin   = vld_p1 ? q_sin_p1 : '0;
    assign bus.o_data_cos   = vld_p1 ? q_cos_p1 : '0;
    assign bus.o_ready      = ready;
    assign bus.o_load_ready = load_ready;

`ifdef SINE_LUT_QUARTERWAVE_ROM_CHECKSUM_EN
    logic [CHECKSUM_WIDTH-1:0] sum;
    logic [CHECKSUM_WIDTH-1:0] sum_next;
    logic                      err;

    assign sum_next = sum + CHECKSUM_WIDTH'(bus.i_load_data);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sum <= '0;
            err <= 1'b0;
        end else if (bus.i_reload) begin
            sum <= '0;
            err <= 1'b0;
        end else if (wr_en) begin
            sum <= sum_next;
            if (last_word) begin
                err <= (sum_next != CHECKSUM);
            end
        end
    end

    assign bus.o_err = err;
`else
    logic unused_checksum;
    assign unused_checksum = ^CHECKSUM;
    assign bus.o_err       = 1'b0;
`endif

endmodule

// File: tb/tb_sine_lut_quarterwave_rom.sv
// Directed bench for sine_lut_quarterwave_rom; checksum steps run when
// SINE_LUT_QUARTERWAVE_ROM_CHECKSUM_EN is defined.
module tb_sine_lut_quarterwave_rom;

    localparam int AW = 11;
    localparam int DW = 12;
    localparam int N  = 2**AW;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    sine_lut_quarterwave_rom_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    sine_lut_quarterwave_rom #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .CHECKSUM   (16'h1800)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic load_words(input int count, input logic [DW-1:0] value, input bit ramp, input int base);
        for (int k = 0; k < count; k++) begin
            bus.i_load_valid = 1'b1;
            bus.i_load_data  = ramp ? DW'(base + k) : value;
            tick();
        end
        bus.i_load_valid = 1'b0;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        bus.i_en         = 1'b0;
        bus.i_addr_sin   = '0;
        bus.i_addr_cos   = '0;
        bus.i_load_data  = '0;
        bus.i_load_valid = 1'b0;
        bus.i_reload     = 1'b0;
        tick();
        tick();

        check("rst_ready",      32'(bus.o_ready), 32'd0);
        check("rst_load_ready", 32'(bus.o_load_ready), 32'd0);
        check("rst_data_sin",   32'(bus.o_data_sin), 32'd0);
        check("rst_data_cos",   32'(bus.o_data_cos), 32'd0);
        check("rst_err",        32'(bus.o_err), 32'd0);

        rst_n = 1'b1;
        tick();
        check("load_ready_up", 32'(bus.o_load_ready), 32'd1);

        // Partial ramp load, then reads during LOAD must give zero
        load_words(500, '0, 1'b1, 0);
        bus.i_en       = 1'b1;
        bus.i_addr_sin = AW'(3);
        bus.i_addr_cos = AW'(4);
        tick();
        check("load_rd_sin",   32'(bus.o_data_sin), 32'd0);
        check("load_rd_cos",   32'(bus.o_data_cos), 32'd0);
        check("load_rd_ready", 32'(bus.o_ready), 32'd0);
        bus.i_en = 1'b0;

        // Reset after 1000 words
        load_words(500, '0, 1'b1, 500);
        check("pre_rst_ready", 32'(bus.o_ready), 32'd0);
        rst_n = 1'b0;
        #1;
        check("midrst_load_ready", 32'(bus.o_load_ready), 32'd0);
        check("midrst_ready",      32'(bus.o_ready), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        check("postrst_load_ready", 32'(bus.o_load_ready), 32'd1);

        // Full ramp with valid toggling every other cycle
        for (int k = 0; k < N; k++) begin
            if (k == N - 1) begin
                check("gap_ready_before_last", 32'(bus.o_ready), 32'd0);
                check("gap_load_ready_before_last", 32'(bus.o_load_ready), 32'd1);
            end
            bus.i_load_valid = 1'b1;
            bus.i_load_data  = DW'(k);
            tick();
            if (k != N - 1) begin
                bus.i_load_valid = 1'b0;
                tick();
            end
        end
        bus.i_load_valid = 1'b0;
        check("ramp_ready",      32'(bus.o_ready), 32'd1);
        check("ramp_load_ready", 32'(bus.o_load_ready), 32'd0);
        check("ramp_data_zero",  32'(bus.o_data_sin), 32'd0);

        bus.i_en       = 1'b1;
        bus.i_addr_sin = AW'(5);
        bus.i_addr_cos = AW'(2042);
        tick();
        check("ramp_sin_5",    32'(bus.o_data_sin), 32'd5);
        check("ramp_cos_2042", 32'(bus.o_data_cos), 32'd2042);

        bus.i_en       = 1'b0;
        bus.i_addr_sin = AW'(2047);
        bus.i_addr_cos = AW'(2047);
        tick();
        check("hold_sin", 32'(bus.o_data_sin), 32'd5);
        check("hold_cos", 32'(bus.o_data_cos), 32'd2042);

        bus.i_en = 1'b1;
        tick();
        check("ramp_sin_2047", 32'(bus.o_data_sin), 32'd2047);
        check("ramp_cos_2047", 32'(bus.o_data_cos), 32'd2047);

        bus.i_addr_sin = AW'(100);
        bus.i_addr_cos = AW'(1);
        bus.i_load_valid = 1'b1;
        bus.i_load_data  = 12'hABC;
        tick();
        bus.i_load_valid = 1'b0;
        check("run_ignore_valid_sin", 32'(bus.o_data_sin), 32'd100);
        check("run_ignore_valid_cos", 32'(bus.o_data_cos), 32'd1);

        // Reload from RUN
        bus.i_reload = 1'b1;
        tick();
        bus.i_reload = 1'b0;
        check("reload_ready",      32'(bus.o_ready), 32'd0);
        check("reload_load_ready", 32'(bus.o_load_ready), 32'd1);
        check("reload_sin_zero",   32'(bus.o_data_sin), 32'd0);
        check("reload_cos_zero",   32'(bus.o_data_cos), 32'd0);
        check("reload_err",        32'(bus.o_err), 32'd0);

        // Reload in LOAD with a simultaneous word: counter restarts, word dropped
        load_words(10, 12'h7FF, 1'b0, 0);
        bus.i_reload     = 1'b1;
        bus.i_load_valid = 1'b1;
        bus.i_load_data  = 12'h123;
        tick();
        bus.i_reload     = 1'b0;
        bus.i_load_valid = 1'b0;
        load_words(N - 1, 12'h7FF, 1'b0, 0);
        check("const_ready_early", 32'(bus.o_ready), 32'd0);
        load_words(1, 12'h7FF, 1'b0, 0);
        check("const_ready", 32'(bus.o_ready), 32'd1);
`ifdef SINE_LUT_QUARTERWAVE_ROM_CHECKSUM_EN
        check("const_err", 32'(bus.o_err), 32'd1);
`else
        check("const_err", 32'(bus.o_err), 32'd0);
`endif

        bus.i_addr_sin = AW'(0);
        bus.i_addr_cos = AW'(1234);
        tick();
        check("const_sin_0",    32'(bus.o_data_sin), 32'h7FF);
        check("const_cos_1234", 32'(bus.o_data_cos), 32'h7FF);

        bus.i_addr_sin = AW'(777);
        bus.i_addr_cos = AW'(777);
        tick();
        check("const_eq_sin", 32'(bus.o_data_sin), 32'h7FF);
        check("const_eq_cos", 32'(bus.o_data_cos), 32'h7FF);

`ifdef SINE_LUT_QUARTERWAVE_ROM_CHECKSUM_EN
        bus.i_reload = 1'b1;
        tick();
        bus.i_reload = 1'b0;
        check("ck_reload_err_clear", 32'(bus.o_err), 32'd0);
        load_words(N, 12'd3, 1'b0, 0);
        check("ck3_ready", 32'(bus.o_ready), 32'd1);
        check("ck3_err",   32'(bus.o_err), 32'd0);

        bus.i_reload = 1'b1;
        tick();
        bus.i_reload = 1'b0;
        load_words(N, 12'd4, 1'b0, 0);
        check("ck4_ready", 32'(bus.o_ready), 32'd1);
        check("ck4_err",   32'(bus.o_err), 32'd1);
        tick();
        check("ck4_sticky", 32'(bus.o_err), 32'd1);
        check("ck4_data",   32'(bus.o_data_sin), 32'd4);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
